// File: rtl/chimera_clu_pwr_seq_if.sv
// Command handshake between the SoC register file (master) and the
// per-cluster power sequencer (slave).
interface chimera_clu_pwr_seq_if;
  logic cmd_valid;
  logic cmd_on;
  logic cmd_ready;

  modport master (
    output cmd_valid,
    output cmd_on,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_on,
    output cmd_ready
  );
endinterface

// File: rtl/chimera_clu_pwr_seq.sv
// Per-cluster power/isolation sequencer: orders clock enable, reset release and
// de-isolation on power-up, and the reverse on power-down, with timed holds.
module chimera_clu_pwr_seq #(
  parameter int unsigned RstHoldCycles = 8,
  parameter int unsigned SettleCycles  = 4,
  parameter int unsigned IsoTimeout    = 1024
) (
  input  logic                        soc_clk_i,
  input  logic                        rst_i,
  chimera_clu_pwr_seq_if.slave        cmd,
  input  logic                        isolated_i,
  output logic                        isolate_o,
  output logic                        clk_en_o,
  output logic                        clu_rst_no,
  output logic                        powered_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int unsigned MaxHold  = (RstHoldCycles > SettleCycles) ? RstHoldCycles : SettleCycles;
  localparam int unsigned MaxLoad  = (MaxHold > IsoTimeout) ? MaxHold : IsoTimeout;
  localparam int unsigned CntWidth = $clog2(MaxLoad + 1);

  localparam logic [CntWidth-1:0] CntOne      = CntWidth'(1);
  localparam logic [CntWidth-1:0] LdRstHold   = CntWidth'(RstHoldCycles);
  localparam logic [CntWidth-1:0] LdSettle    = CntWidth'(SettleCycles);
  localparam logic [CntWidth-1:0] LdIsoTimout = CntWidth'(IsoTimeout);

  localparam logic [2:0] ST_OFF        = 3'd0;
  localparam logic [2:0] ST_CLK_ON     = 3'd1;
  localparam logic [2:0] ST_RST_REL    = 3'd2;
  localparam logic [2:0] ST_DEISO      = 3'd3;
  localparam logic [2:0] ST_ON         = 3'd4;
  localparam logic [2:0] ST_ISO        = 3'd5;
  localparam logic [2:0] ST_RST_ASSERT = 3'd6;
  localparam logic [2:0] ST_CLK_OFF    = 3'd7;

  logic [2:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic                cmd_ready;
  logic                cmd_accept;
  logic                cnt_last;
  logic [CntWidth-1:0] cnt_dec;

  assign cmd_ready  = (state_q == ST_OFF) || (state_q == ST_ON);
  assign cmd_accept = cmd.cmd_valid && cmd_ready;
  assign cnt_last   = (cnt_q == CntOne);
  // Saturating decrement keeps the counter from ever wrapping below 1.
  assign cnt_dec    = (cnt_q > CntOne) ? (cnt_q - CntOne) : cnt_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_dec;
    timeout_d = timeout_q;

    case (state_q)
      ST_OFF: begin
        cnt_d = cnt_q;
        if (cmd_accept) begin
          timeout_d = 1'b0;
          if (cmd.cmd_on) begin
            state_d = ST_CLK_ON;
            cnt_d   = LdRstHold;
          end
        end
      end
      ST_CLK_ON: begin
        if (cnt_last) begin
          state_d = ST_RST_REL;
          cnt_d   = LdSettle;
        end
      end
      ST_RST_REL: begin
        if (cnt_last) begin
          state_d = ST_DEISO;
          cnt_d   = LdIsoTimout;
        end
      end
      ST_DEISO: begin
        // A cluster that never reports de-isolation still gets marked powered,
        // but the sticky timeout flag tells software something went wrong.
        if (!isolated_i) begin
          state_d = ST_ON;
        end else if (cnt_last) begin
          state_d   = ST_ON;
          timeout_d = 1'b1;
        end
      end
      ST_ON: begin
        cnt_d = cnt_q;
        if (cmd_accept) begin
          timeout_d = 1'b0;
          if (!cmd.cmd_on) begin
            state_d = ST_ISO;
            cnt_d   = LdIsoTimout;
          end
        end
      end
      ST_ISO: begin
        if (isolated_i) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = LdRstHold;
        end else if (cnt_last) begin
          state_d   = ST_RST_ASSERT;
          cnt_d     = LdRstHold;
          timeout_d = 1'b1;
        end
      end
      ST_RST_ASSERT: begin
        if (cnt_last) begin
          state_d = ST_CLK_OFF;
          cnt_d   = LdSettle;
        end
      end
      ST_CLK_OFF: begin
        if (cnt_last) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge soc_clk_i) begin
    if (rst_i) begin
      state_q   <= ST_OFF;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs depend on the state register only, so no input reaches an output
  // combinationally.
  always_comb begin
    isolate_o  = 1'b1;
    clk_en_o   = 1'b0;
    clu_rst_no = 1'b0;
    case (state_q)
      ST_OFF:        begin isolate_o = 1'b1; clk_en_o = 1'b0; clu_rst_no = 1'b0; end
      ST_CLK_ON:     begin isolate_o = 1'b1; clk_en_o = 1'b1; clu_rst_no = 1'b0; end
      ST_RST_REL:    begin isolate_o = 1'b1; clk_en_o = 1'b1; clu_rst_no = 1'b1; end
      ST_DEISO:      begin isolate_o = 1'b0; clk_en_o = 1'b1; clu_rst_no = 1'b1; end
      ST_ON:         begin isolate_o = 1'b0; clk_en_o = 1'b1; clu_rst_no = 1'b1; end
      ST_ISO:        begin isolate_o = 1'b1; clk_en_o = 1'b1; clu_rst_no = 1'b1; end
      ST_RST_ASSERT: begin isolate_o = 1'b1; clk_en_o = 1'b1; clu_rst_no = 1'b0; end
      ST_CLK_OFF:    begin isolate_o = 1'b1; clk_en_o = 1'b0; clu_rst_no = 1'b0; end
      default:       begin isolate_o = 1'b1; clk_en_o = 1'b0; clu_rst_no = 1'b0; end
    endcase
  end

  assign powered_o     = (state_q == ST_ON);
  assign busy_o        = !cmd_ready;
  assign timeout_o     = timeout_q;
  assign cmd.cmd_ready = cmd_ready;

endmodule

// File: tb/tb_chimera_clu_pwr_seq.sv
// Directed bench for chimera_clu_pwr_seq: vector table for the nominal up/down
// sequences, hand-written sequences for timeouts, busy holds and mid-run reset.
module tb_chimera_clu_pwr_seq;

  // Output vector order: {isolate, clk_en, clu_rst_n, powered, busy, ready, timeout}
  localparam logic [6:0] OFF_O    = 7'b1000010;
  localparam logic [6:0] CLKON_O  = 7'b1100100;
  localparam logic [6:0] RSTREL_O = 7'b1110100;
  localparam logic [6:0] DEISO_O  = 7'b0110100;
  localparam logic [6:0] ON_O     = 7'b0111010;
  localparam logic [6:0] ISO_O    = 7'b1110100;
  localparam logic [6:0] RSTA_O   = 7'b1100100;
  localparam logic [6:0] CLKOFF_O = 7'b1000100;
  localparam logic [6:0] TO       = 7'b0000001;

  logic soc_clk = 1'b0;
  logic rst;
  logic isolated;
  logic isolate, clk_en, clu_rst_n, powered, busy, timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       valid;
    logic       on;
    logic       iso;
    logic [6:0] exp;
    int         reps;
    string      name;
  } vec_t;

  vec_t tbl[$];

  chimera_clu_pwr_seq_if cmd_if ();

  chimera_clu_pwr_seq #(
    .RstHoldCycles(8),
    .SettleCycles (4),
    .IsoTimeout   (16)
  ) dut (
    .soc_clk_i (soc_clk),
    .rst_i     (rst),
    .cmd       (cmd_if),
    .isolated_i(isolated),
    .isolate_o (isolate),
    .clk_en_o  (clk_en),
    .clu_rst_no(clu_rst_n),
    .powered_o (powered),
    .busy_o    (busy),
    .timeout_o (timeout)
  );

  always #5 soc_clk = ~soc_clk;

  task automatic applyStimulus(input logic valid, input logic on, input logic iso, input logic r);
    cmd_if.cmd_valid = valid;
    cmd_if.cmd_on    = on;
    isolated         = iso;
    rst              = r;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge soc_clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [6:0] exp);
    logic [6:0] got;
    got = {isolate, clk_en, clu_rst_n, powered, busy, cmd_if.cmd_ready, timeout};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b (iso,clk,rstn,pwr,busy,rdy,to)", name, got, exp);
    end
  endtask

  function automatic void add(input logic valid, input logic on, input logic iso,
                              input logic [6:0] exp, input int reps, input string name);
    vec_t v;
    v.valid = valid;
    v.on    = on;
    v.iso   = iso;
    v.exp   = exp;
    v.reps  = reps;
    v.name  = name;
    tbl.push_back(v);
  endfunction

  // Power-up where the cluster already reports de-isolated on DEISO entry.
  task automatic power_up_fast(input string tag);
    applyStimulus(1, 1, 1, 0);
    checkOutput({tag, "_accept"}, OFF_O);
    tick(1);
    applyStimulus(0, 0, 1, 0);
    tick(11);
    applyStimulus(0, 0, 0, 0);
    tick(1);
    checkOutput({tag, "_deiso"}, DEISO_O);
    tick(1);
    checkOutput({tag, "_on"}, ON_O);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    add(1, 1, 1, OFF_O,    1, "pu_accept");
    add(0, 0, 0, CLKON_O,  4, "pu_clk_on_glitch");
    add(0, 0, 1, CLKON_O,  4, "pu_clk_on");
    add(0, 0, 1, RSTREL_O, 4, "pu_rst_rel");
    add(0, 0, 1, DEISO_O,  2, "pu_deiso_wait");
    add(0, 0, 0, DEISO_O,  1, "pu_deiso_drop");
    add(0, 0, 0, ON_O,     1, "pu_on");
    add(1, 0, 0, ON_O,     1, "pd_accept");
    add(0, 0, 0, ISO_O,    3, "pd_iso_wait");
    add(0, 0, 1, ISO_O,    1, "pd_iso_rise");
    add(0, 0, 1, RSTA_O,   8, "pd_rst_assert");
    add(0, 0, 1, CLKOFF_O, 4, "pd_clk_off");
    add(0, 0, 1, OFF_O,    1, "pd_off");
    add(1, 0, 1, OFF_O,    1, "off_noop_accept");
    add(0, 0, 0, OFF_O,    2, "off_glitch_ignored");
    add(0, 0, 1, OFF_O,    1, "off_idle");

    applyStimulus(0, 0, 1, 1);
    tick(2);
    checkOutput("reset_state", OFF_O);

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        applyStimulus(tbl[i].valid, tbl[i].on, tbl[i].iso, 0);
        checkOutput($sformatf("%s[%0d]", tbl[i].name, r), tbl[i].exp);
        tick(1);
      end
    end

    $display("[TB] timeout scenarios");
    power_up_fast("fast1");
    applyStimulus(1, 0, 0, 0);
    tick(1);
    applyStimulus(0, 0, 0, 0);
    tick(15);
    checkOutput("iso_last_wait", ISO_O);
    tick(1);
    checkOutput("iso_timeout_forced", RSTA_O | TO);
    tick(8);
    checkOutput("iso_timeout_clk_off", CLKOFF_O | TO);
    tick(4);
    checkOutput("timeout_sticky_off", OFF_O | TO);
    tick(3);
    checkOutput("timeout_sticky_idle", OFF_O | TO);

    applyStimulus(1, 1, 1, 0);
    tick(1);
    checkOutput("timeout_cleared", CLKON_O);
    applyStimulus(0, 0, 1, 0);
    tick(12);
    checkOutput("deiso_first_wait", DEISO_O);
    tick(15);
    checkOutput("deiso_last_wait", DEISO_O);
    tick(1);
    checkOutput("deiso_timeout", ON_O | TO);

    applyStimulus(1, 1, 0, 0);
    tick(1);
    checkOutput("on_noop", ON_O);
    applyStimulus(0, 0, 0, 0);
    tick(2);
    checkOutput("on_noop_hold", ON_O);

    $display("[TB] busy hold scenario");
    applyStimulus(1, 0, 0, 0);
    tick(1);
    applyStimulus(1, 1, 0, 0);
    checkOutput("busy_no_accept", ISO_O);
    tick(3);
    applyStimulus(1, 1, 1, 0);
    tick(1);
    checkOutput("busy_rst_assert", RSTA_O);
    tick(12);
    checkOutput("pending_on_ready", OFF_O);
    tick(1);
    checkOutput("pending_on_taken", CLKON_O);
    applyStimulus(0, 0, 1, 0);

    $display("[TB] reset mid-sequence");
    tick(12);
    checkOutput("pre_reset_deiso", DEISO_O);
    applyStimulus(0, 0, 1, 1);
    tick(1);
    checkOutput("reset_in_deiso", OFF_O);
    applyStimulus(0, 0, 1, 0);
    tick(1);
    checkOutput("after_reset_deiso", OFF_O);

    power_up_fast("fast2");
    applyStimulus(1, 0, 0, 0);
    tick(1);
    applyStimulus(0, 0, 1, 0);
    tick(1);
    checkOutput("iso_one_cycle", RSTA_O);
    applyStimulus(0, 0, 1, 1);
    tick(1);
    checkOutput("reset_in_rst_assert", OFF_O);
    applyStimulus(0, 0, 1, 0);
    tick(1);

    power_up_fast("fast3");
    applyStimulus(1, 0, 0, 0);
    tick(1);
    applyStimulus(0, 0, 1, 0);
    tick(1);
    checkOutput("final_rst_assert", RSTA_O);
    tick(8);
    checkOutput("final_clk_off", CLKOFF_O);
    tick(4);
    checkOutput("final_off", OFF_O);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
